// File: rtl/apb_req_master_pkg.sv
// apb_req_master_pkg: shared state and response types for the APB request master
package apb_req_master_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_mst_state_e;
  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        timeout;
  } apb_rsp_t;
endpackage

// File: rtl/apb_req_master_if.sv
// apb_req_master_if: core-side req/gnt/rvalid port plus APB3 bus signals
interface apb_req_master_if #(parameter int AW = 12);
  logic          req_i;
  logic [AW-1:0] addr_i;
  logic          we_i;
  logic [31:0]   wdata_i;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic          timeout_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;
  modport master (
    input  req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
    output gnt_o, rvalid_o, rdata_o, err_o, timeout_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
  modport slave (
    output req_i, addr_i, we_i, wdata_i, PRDATA, PREADY, PSLVERR,
    input  gnt_o, rvalid_o, rdata_o, err_o, timeout_o, PADDR, PWDATA, PWRITE, PSEL, PENABLE
  );
endinterface

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt: counts PREADY=0 ACCESS cycles and flags the abort cycle
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    if (rst || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  assign expired = (TIMEOUT_CYCLES != 0) && enable && (cnt == W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/apb_req_master.sv
// apb_req_master: single-outstanding req/gnt/rvalid to APB3 initiator with watchdog
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic HCLK,
  input logic HRESET,
  apb_req_master_if.master bus
);
  apb_mst_state_e state, state_n;
  apb_rsp_t rsp;
  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic in_access, expired, done;
  assign in_access = state == ACCESS;
  assign done = in_access && (bus.PREADY || expired);
  assign bus.gnt_o = (state == IDLE) && bus.req_i && !HRESET;
  assign bus.PADDR = paddr;
  assign {bus.rdata_o, bus.err_o, bus.timeout_o} = rsp;
  always_comb
    state_n = state == IDLE  ? (bus.gnt_o ? SETUP : IDLE) :
              state == SETUP ? ACCESS :
              done           ? IDLE : ACCESS;
  apb_timeout_cnt #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_cnt (
    .clk    (HCLK),
    .rst    (HRESET),
    .clear  (state == SETUP),
    .enable (in_access && !bus.PREADY),
    .expired(expired)
  );
  always_ff @(posedge HCLK)
    if (HRESET) begin
      state        <= IDLE;
      bus.PSEL     <= 1'b0;
      bus.PENABLE  <= 1'b0;
      bus.PWRITE   <= 1'b0;
      bus.PWDATA   <= '0;
      paddr        <= '0;
      bus.rvalid_o <= 1'b0;
      rsp          <= '0;
    end else begin
      state        <= state_n;
      bus.PSEL     <= state_n != IDLE;
      bus.PENABLE  <= state_n == ACCESS;
      bus.rvalid_o <= done;
      if (bus.gnt_o) begin
        paddr      <= bus.addr_i;
        bus.PWRITE <= bus.we_i;
        bus.PWDATA <= bus.wdata_i;
      end
      if (done)
        rsp <= bus.PREADY ? apb_rsp_t'{rdata: bus.PWRITE ? '0 : bus.PRDATA, err: bus.PSLVERR, timeout: 1'b0}
                          : apb_rsp_t'{rdata: '0, err: 1'b1, timeout: 1'b1};
    end
endmodule
